// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC-array job sequencer.
//   N, DW, AW   : lane count, per-lane data/weight width, per-column accumulator width
//   seq_state_e : job controller states
//   lane_byte() : pull one lane's byte out of a packed N*DW vector
package mac_seq_pkg;

    localparam int N  = 5;
    localparam int DW = 8;
    localparam int AW = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } seq_state_e;

    function automatic logic [DW-1:0] lane_byte(input logic [N*DW-1:0] vec, input int lane);
        return vec[lane*DW +: DW];
    endfunction

endpackage

// File: rtl/mac_array_sequencer_skew_line.sv
// skew_line: fixed-depth shift-register delay, cleared by the async reset.
// Used for the per-lane input skew, the per-column output deskew and the
// vector valid-token pipe.
//   CLK, RSTN : clock, asynchronous active-low reset
//   d_i       : value entering the line
//   q_o       : d_i delayed by DEPTH cycles (DEPTH >= 1)
module skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mac_array_sequencer.sv
// mac_array_sequencer: job controller for the 5x5 weight-stationary MAC array.
// Loads five weight rows, streams T input vectors into the array with a
// per-lane diagonal skew, deskews the result columns and emits one aligned
// output vector (low byte per column) plus an overflow flag per input vector.
//   CLK, RSTN                         : clock, async active-low reset
//   start_i, t_len_i                  : job request and vector count (1..T_MAX)
//   busy_o, err_o, done_o             : job status, bad-request pulse, completion pulse
//   w_valid_i/w_ready_o/w_data_i      : weight-row stream (byte j = column j)
//   x_valid_i/x_ready_o/x_data_i      : input-vector stream (byte i = lane i)
//   arr_wload_o/arr_wsel_o/arr_wdata_o: weight row write into the array
//   arr_clr_o                         : accumulator clear, issued with the last weight row
//   arr_x_o/arr_xv_o                  : skewed lane data / lane valid into the array
//   arr_y_i                           : array result columns, column j = [AW*j +: AW]
//   out_valid_o/out_data_o/out_ov_o   : aligned result vector and overflow flag
//   job_ov_o                          : sticky overflow for the current job
module mac_array_sequencer
    import mac_seq_pkg::*;
#(
    parameter int T_MAX   = 16,
    parameter int ARR_LAT = 5
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            start_i,
    input  logic [4:0]      t_len_i,
    output logic            busy_o,
    output logic            err_o,
    input  logic            w_valid_i,
    output logic            w_ready_o,
    input  logic [N*DW-1:0] w_data_i,
    input  logic            x_valid_i,
    output logic            x_ready_o,
    input  logic [N*DW-1:0] x_data_i,
    output logic            arr_wload_o,
    output logic [2:0]      arr_wsel_o,
    output logic [N*DW-1:0] arr_wdata_o,
    output logic            arr_clr_o,
    output logic [N*DW-1:0] arr_x_o,
    output logic [N-1:0]    arr_xv_o,
    input  logic [N*AW-1:0] arr_y_i,
    output logic            out_valid_o,
    output logic [N*DW-1:0] out_data_o,
    output logic            out_ov_o,
    output logic            job_ov_o,
    output logic            done_o
);

    localparam logic [5:0] TMAX6 = 6'(T_MAX);
    localparam logic [2:0] WLAST = 3'(N-1);

    seq_state_e      state_q, state_d;
    logic [2:0]      wcnt_q, wcnt_d;
    logic [4:0]      tlen_q, tlen_d;
    logic [4:0]      xcnt_q, xcnt_d;
    logic [4:0]      ocnt_q, ocnt_d;
    logic            job_ov_q, job_ov_d;
    logic            err_q, err_d;
    logic            out_valid_q;
    logic [N*DW-1:0] out_data_q, out_data_d;
    logic            out_ov_q, out_ov_d;

    logic            start_ok;
    logic            x_hs;
    logic            tok;
    logic [DW:0]     lane_in  [N];
    logic [DW:0]     lane_out [N];
    logic [AW-1:0]   col_al   [N];

    assign start_ok = (t_len_i != 5'd0) && ({1'b0, t_len_i} <= TMAX6);
    assign x_hs     = x_ready_o & x_valid_i;

    // Control FSM: next state, counters and handshake outputs
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        tlen_d      = tlen_q;
        xcnt_d      = xcnt_q;
        ocnt_d      = ocnt_q + {4'd0, out_valid_q};
        job_ov_d    = job_ov_q | out_ov_q;
        err_d       = 1'b0;
        w_ready_o   = 1'b0;
        x_ready_o   = 1'b0;
        arr_wload_o = 1'b0;
        arr_wsel_o  = 3'd0;
        arr_wdata_o = '0;
        arr_clr_o   = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (start_ok) begin
                        tlen_d   = t_len_i;
                        job_ov_d = 1'b0;
                        wcnt_d   = 3'd0;
                        xcnt_d   = 5'd0;
                        ocnt_d   = 5'd0;
                        state_d  = ST_LOAD_W;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD_W: begin
                w_ready_o = 1'b1;
                if (w_valid_i) begin
                    arr_wload_o = 1'b1;
                    arr_wsel_o  = wcnt_q;
                    arr_wdata_o = w_data_i;
                    if (wcnt_q == WLAST) begin
                        // Clearing with the last row leaves the array ready for the first vector
                        arr_clr_o = 1'b1;
                        wcnt_d    = 3'd0;
                        state_d   = ST_STREAM;
                    end else begin
                        wcnt_d = wcnt_q + 3'd1;
                    end
                end
            end
            ST_STREAM: begin
                x_ready_o = 1'b1;
                if (x_valid_i) begin
                    if (xcnt_q + 5'd1 == tlen_q) begin
                        xcnt_d  = 5'd0;
                        state_d = ST_DRAIN;
                    end else begin
                        xcnt_d = xcnt_q + 5'd1;
                    end
                end
            end
            ST_DRAIN: begin
                // ocnt_q already includes the final output, so done lands one cycle after it
                if (ocnt_q == tlen_q) begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Input skew: lane i sees the vector 1+i cycles after acceptance; idle cycles are zero bubbles
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lane_in[i] = {x_hs, x_hs ? lane_byte(x_data_i, i) : {DW{1'b0}}};
        skew_line #(.DEPTH(1 + i), .WIDTH(DW + 1)) u_xskew (
            .CLK  (CLK),
            .RSTN (RSTN),
            .d_i  (lane_in[i]),
            .q_o  (lane_out[i])
        );
        assign arr_x_o[i*DW +: DW] = lane_out[i][DW-1:0];
        assign arr_xv_o[i]         = lane_out[i][DW];
    end

    // Output deskew: column j arrives j cycles after column 0, so it is delayed N-1-j
    for (genvar j = 0; j < N; j++) begin : g_col
        if (N - 1 - j > 0) begin : g_dly
            skew_line #(.DEPTH(N - 1 - j), .WIDTH(AW)) u_yskew (
                .CLK  (CLK),
                .RSTN (RSTN),
                .d_i  (arr_y_i[j*AW +: AW]),
                .q_o  (col_al[j])
            );
        end else begin : g_thru
            assign col_al[j] = arr_y_i[j*AW +: AW];
        end
    end

    // One token per accepted vector, timed to meet the fully deskewed result
    skew_line #(.DEPTH(ARR_LAT + N), .WIDTH(1)) u_tok (
        .CLK  (CLK),
        .RSTN (RSTN),
        .d_i  (x_hs),
        .q_o  (tok)
    );

    // Overflow means any column's accumulator has bits above the emitted byte
    always_comb begin
        out_data_d = '0;
        out_ov_d   = 1'b0;
        for (int j = 0; j < N; j++) begin
            out_data_d[j*DW +: DW] = tok ? col_al[j][DW-1:0] : {DW{1'b0}};
            if (tok && (col_al[j][AW-1:DW] != '0)) begin
                out_ov_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 3'd0;
            tlen_q      <= 5'd0;
            xcnt_q      <= 5'd0;
            ocnt_q      <= 5'd0;
            job_ov_q    <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ov_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            tlen_q      <= tlen_d;
            xcnt_q      <= xcnt_d;
            ocnt_q      <= ocnt_d;
            job_ov_q    <= job_ov_d;
            err_q       <= err_d;
            out_valid_q <= tok;
            out_data_q  <= out_data_d;
            out_ov_q    <= out_ov_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ov_o    = out_ov_q;
    assign job_ov_o    = job_ov_q | out_ov_q;

endmodule

// File: doc/mac_array_sequencer.md
# mac_array_sequencer

Job controller for the 5x5 weight-stationary MAC array. It accepts a matrix-multiply job from the host and loads five 40-bit weight rows into the array. It then streams T 40-bit input vectors with per-lane diagonal skew, deskews the array's result columns, and emits one aligned 40-bit output vector per input vector with an overflow flag. It sits between the host/DMA streams and the MAC array and owns all array sequencing.

## Interface
- N, 5: array dimension (lanes); fixed at 5 for 40-bit buses
- DW, 8: data/weight width per lane
- AW, 16: accumulator width per column
- T_MAX, 16: maximum vectors per job
- ARR_LAT, 5: cycles from array lane-0 input to result column 0 valid
- CLK  in  1  clock, rising edge
- RSTN  in  1  reset, asynchronous, active-low
- start_i  in  1  job request; accepted when busy_o=0 and t_len_i!=0
- t_len_i  in  5  vectors in job (1..T_MAX), sampled on accept
- busy_o  out  1  job in progress
- err_o  out  1  one-cycle pulse: start_i with t_len_i=0 or t_len_i>T_MAX while idle
- w_valid_i / w_ready_o / w_data_i  in/out/in  1/1/40  weight-row stream, byte j = column j
- x_valid_i / x_ready_o / x_data_i  in/out/in  1/1/40  input-vector stream, byte i = lane i
- arr_wload_o, arr_wsel_o[2:0], arr_wdata_o[39:0]  out  weight write to array row wsel
- arr_clr_o  out  1  clears array accumulators
- arr_x_o[39:0], arr_xv_o[4:0]  out  skewed lane data/valid
- arr_y_i  in  80  array result columns, column j = [16j+:16]
- out_valid_o, out_data_o[39:0], out_ov_o  out  aligned result; sink is always ready
- job_ov_o  out  1  sticky OR of out_ov_o for current job, cleared on accept
- done_o  out  1  one-cycle job-complete pulse

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE: on an accepted start, latch t_len, clear job_ov_o, go to LOAD_W. busy_o=1 in every state except IDLE.
- LOAD_W: w_ready_o=1.
  - Each handshake drives, combinationally in the same cycle: arr_wload_o=1, arr_wsel_o=wcnt, arr_wdata_o=w_data_i.
  - wcnt counts 0..4. On the 5th beat, arr_clr_o=1 in the same cycle, wcnt wraps to 0, and the state goes to STREAM.
- STREAM: x_ready_o=1.
  - An accepted beat enters the skew lines. Lane i gets a delay of 1+i registers.
  - A cycle with no beat inserts a bubble: zero data, lane valid 0.
  - After t_len beats go to DRAIN. x_ready_o=0 from that cycle on.
- Output path:
  - Column j of arr_y_i is delayed N-1-j cycles.
  - A valid token per vector travels a matching pipe.
  - Output register: out_data_o byte j = y_j[7:0]; out_ov_o = OR over j of (y_j[15:8]!=0), unsigned.
- DRAIN: wait until the output count equals t_len. Then pulse done_o and go to IDLE; busy_o=0 on the same edge.
- start_i while busy: ignored, no err_o.
- Reset (including mid-job): state IDLE; all counters, skew/deskew registers and valid pipes clear. Every output resets to 0; w_ready_o and x_ready_o are 0.

## Timing
- Accept at edge c: LOAD_W from c+1. The first weight beat is possible in cycle c+1.
- Five back-to-back weight beats take cycles c+1..c+5. STREAM starts in c+6.
- Vector accepted in cycle a:
  - lane i appears on arr_x_o in cycle a+1+i;
  - out_valid_o in cycle a+ARR_LAT+N+1, which is a+11 at defaults.
- Full throughput: one vector per cycle, with no bubbles inserted by the block.
- done_o occurs one cycle after the final out_valid_o.
- The next start may be accepted in the cycle after done_o.

## Structure
- Package mac_seq_pkg holds:
  - the state enum;
  - N, DW and AW constants;
  - a lane-byte extract function.
- Sub-module skew_line (parameter DEPTH, WIDTH): a reset-clearable shift-register delay. It is used for the 5 input lanes, the 5 output columns and the valid pipe.

## Test plan
- Identity weights (row i = 0x01 at byte i), t_len=3, x = 0x0504030201, 0x0A09080706, 0xFFEEDDCCBB back-to-back:
  - out_data_o equals x in order at a+11, a+12, a+13;
  - out_ov_o=0;
  - done_o one cycle after the last output.
- Weights all 0xFF, x = 0x0202020202, t_len=1:
  - each column sums to 2550 = 0x09F6;
  - out_data_o = 0xF6F6F6F6F6, out_ov_o=1, job_ov_o=1 until the next accept.
- Identity weights, t_len=4, x_valid_i dropped for 2 cycles after the 2nd beat:
  - outputs in order with a matching 2-cycle gap;
  - exactly 4 out_valid_o pulses;
  - arr_xv_o shows bubbles.
- start_i with t_len_i=0 → err_o pulse, busy_o stays 0. start_i during STREAM → ignored, job completes normally.
- RSTN asserted mid-STREAM after 2 of 5 vectors:
  - all outputs are 0 immediately;
  - a subsequent job with t_len=2 produces correct results with no stale outputs.
- Weight beats with w_valid_i gaps (one beat every 3 cycles):
  - arr_wsel_o sequences 0..4;
  - arr_clr_o pulses exactly once, with the 5th beat.
